dmem_sram_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the load/store path the CPU MEM stage drives.

---
 rtl/dmem_sram_responder_pkg.sv | 14 +
 rtl/dmem_sram_responder_byte_mask_gen.sv | 35 +++
 rtl/dmem_sram_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_sram_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_sram_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM state codes.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_sram_responder_byte_mask_gen.sv
// Expected byte-lane mask and alignment legality for a size/offset pair.
module byte_mask_gen
    import dmem_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] offset,
    output logic [3:0] mask,
    output logic       aligned
);

    // Size 11 falls to the default: no lanes, never legal.
    always_comb begin
        mask    = 4'b0000;
        aligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                mask    = 4'b0001 << offset;
                aligned = 1'b1;
            end
            SIZE_HALF: begin
                mask    = 4'b0011 << offset;
                aligned = ~offset[0];
            end
            SIZE_WORD: begin
                mask    = 4'b1111;
                aligned = (offset == 2'b00);
            end
            default: begin
                mask    = 4'b0000;
                aligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_sram_responder.sv
// Memory-side responder for the CPU load/store path: one request at a time on a
// req/addr_ok/data_ok handshake, byte-lane writes, full-word reads, error flagging.
module dmem_sram_responder
    import dmem_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int CW    = $clog2(LATENCY + 1);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2 + 2;

    logic [31:0] mem [0:DEPTH-1];

    state_t          state_r, state_next_s;
    logic [CW-1:0]   cnt_r, cnt_next_s;
    logic            accept_s;
    logic            wr_r;
    logic [1:0]      size_r;
    logic [AW-1:0]   addr_r;
    logic [3:0]      wstrb_r;
    logic [31:0]     wdata_r;

    logic            txn_wr_s;
    logic [1:0]      txn_size_s;
    logic [AW-1:0]   txn_addr_s;
    logic [3:0]      txn_wstrb_s;
    logic [31:0]     txn_wdata_s;
    logic [3:0]      mask_s;
    logic            aligned_s;
    logic            bad_s;
    logic            resp_entry_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic            unused_addr_s;

    // Upper address bits alias onto the array.
    assign unused_addr_s = ^addr[31:AW];

    assign addr_ok  = (state_r == S_IDLE);
    assign accept_s = req && addr_ok;

    // With LATENCY==1 the response is formed on the accept edge, so the live inputs stand in for the latch.
    assign txn_wr_s    = (state_r == S_IDLE) ? wr            : wr_r;
    assign txn_size_s  = (state_r == S_IDLE) ? size          : size_r;
    assign txn_addr_s  = (state_r == S_IDLE) ? addr[AW-1:0]  : addr_r;
    assign txn_wstrb_s = (state_r == S_IDLE) ? wstrb         : wstrb_r;
    assign txn_wdata_s = (state_r == S_IDLE) ? wdata         : wdata_r;
    assign idx_s       = txn_addr_s[AW-1:2];

    byte_mask_gen u_mask (
        .size    (txn_size_s),
        .offset  (txn_addr_s[1:0]),
        .mask    (mask_s),
        .aligned (aligned_s)
    );

    assign bad_s        = !aligned_s || (txn_wr_s && (txn_wstrb_s != mask_s));
    assign resp_entry_s = (state_next_s == S_RESP);

    // Next-state and latency counter.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    cnt_next_s   = CW'(LATENCY - 1);
                    state_next_s = (LATENCY == 1) ? S_RESP : S_WAIT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_next_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_next_s = S_RESP;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_RESP: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Request latch, loaded only in the accept window.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_r    <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= '0;
            wstrb_r <= 4'b0000;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            wr_r    <= wr;
            size_r  <= size;
            addr_r  <= addr[AW-1:0];
            wstrb_r <= wstrb;
            wdata_r <= wdata;
        end
    end

    // Response registers; err/rdata hold until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_ok <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'h0000_0000;
        end else begin
            data_ok <= resp_entry_s;
            if (resp_entry_s) begin
                err   <= bad_s;
                rdata <= (bad_s || txn_wr_s) ? 32'h0000_0000 : mem[idx_s];
            end
        end
    end

    // Lane-wise write commit on the edge that raises data_ok.
    always_ff @(posedge clk) begin
        if (!rst && resp_entry_s && txn_wr_s && !bad_s) begin
            for (int i = 0; i < 4; i++) begin
                if (txn_wstrb_s[i]) begin
                    mem[idx_s][8*i +: 8] <= txn_wdata_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Scoreboard bench for dmem_sram_responder: LATENCY=2 main instance plus a LATENCY=3 instance for accept timing.
module tb_dmem_sram_responder;
    import dmem_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct packed {
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [3:0]  st;
        logic [31:0] wd;
        logic        xe;
        logic [31:0] xr;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok, err;
    logic [31:0] rdata;

    logic        req3;
    logic        wr3 = 1'b0;
    logic [1:0]  size3 = 2'b10;
    logic [31:0] addr3 = 32'h0000_0000;
    logic [3:0]  wstrb3 = 4'b0000;
    logic [31:0] wdata3 = 32'h0000_0000;
    logic        addr_ok3, data_ok3, err3;
    logic [31:0] rdata3;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_sram_responder #(.DEPTH_LOG2(10), .LATENCY(2), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .err(err)
    );

    dmem_sram_responder #(.DEPTH_LOG2(6), .LATENCY(3), .INIT_FILE("")) dut3 (
        .clk(clk), .rst(rst), .req(req3), .wr(wr3), .size(size3), .addr(addr3),
        .wstrb(wstrb3), .wdata(wdata3), .addr_ok(addr_ok3), .data_ok(data_ok3),
        .rdata(rdata3), .err(err3)
    );

    // Drive one request, push its expectation, then wait (bounded) for the response and pop.
    task automatic run_txn(input txn_t t, output logic ok, output int lat,
                           output logic [31:0] r, output logic e,
                           output logic pulse_ok, output exp_t ex);
        int wait_n;
        @(negedge clk);
        req = 1'b1; wr = t.w; size = t.sz; addr = t.a; wstrb = t.st; wdata = t.wd;
        wait_n = 0;
        while (!addr_ok && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        sb.push_back('{err: t.xe, rdata: t.xr});
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 1;
        while (!data_ok && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = data_ok && addr_ok === 1'b0;
        r  = rdata;
        e  = err;
        @(posedge clk);
        #1;
        pulse_ok = !data_ok && (rdata === r) && (err === e);
        ex = sb.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; req3 = 1'b0;
        wr = 1'b0; size = SIZE_WORD; addr = 32'h0; wstrb = 4'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (addr_ok !== 1'b1 || data_ok !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: addr_ok=%b data_ok=%b err=%b rdata=%h, want 1 0 0 00000000",
                     addr_ok, data_ok, err, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (addr_ok !== 1'b1 || addr_ok3 !== 1'b1 || data_ok !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: addr_ok=%b addr_ok3=%b data_ok=%b, want 1 1 0",
                     addr_ok, addr_ok3, data_ok);
        end
    endtask

    task automatic test_sw_lw();
        txn_t tbl[2];
        logic ok, e, p; int lat; logic [31:0] r; exp_t ex;
        tbl[0] = '{w: 1'b1, sz: SIZE_WORD, a: 32'h10, st: 4'b1111, wd: 32'hDEADBEEF, xe: 1'b0, xr: 32'h0};
        tbl[1] = '{w: 1'b0, sz: SIZE_WORD, a: 32'h10, st: 4'b0000, wd: 32'h0, xe: 1'b0, xr: 32'hDEADBEEF};
        for (int i = 0; i < 2; i++) begin
            run_txn(tbl[i], ok, lat, r, e, p, ex);
            checks++;
            if (!ok || lat != 2 || e !== ex.err || r !== ex.rdata || !p) begin
                errors++;
                $display("FAIL sw_lw[%0d]: ok=%b lat=%0d err=%b rdata=%h pulse=%b, want ok=1 lat=2 err=%b rdata=%h pulse=1",
                         i, ok, lat, e, r, p, ex.err, ex.rdata);
            end
        end
    endtask

    task automatic test_partial();
        txn_t tbl[4];
        logic ok, e, p; int lat; logic [31:0] r; exp_t ex;
        tbl[0] = '{w: 1'b1, sz: SIZE_BYTE, a: 32'h13, st: 4'b1000, wd: 32'hAAAAAAAA, xe: 1'b0, xr: 32'h0};
        tbl[1] = '{w: 1'b0, sz: SIZE_WORD, a: 32'h10, st: 4'b0000, wd: 32'h0, xe: 1'b0, xr: 32'hAAADBEEF};
        tbl[2] = '{w: 1'b1, sz: SIZE_HALF, a: 32'h12, st: 4'b1100, wd: 32'h12341234, xe: 1'b0, xr: 32'h0};
        tbl[3] = '{w: 1'b0, sz: SIZE_WORD, a: 32'h10, st: 4'b0000, wd: 32'h0, xe: 1'b0, xr: 32'h1234BEEF};
        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i], ok, lat, r, e, p, ex);
            checks++;
            if (!ok || lat != 2 || e !== ex.err || r !== ex.rdata || !p) begin
                errors++;
                $display("FAIL partial[%0d]: ok=%b lat=%0d err=%b rdata=%h pulse=%b, want ok=1 lat=2 err=%b rdata=%h pulse=1",
                         i, ok, lat, e, r, p, ex.err, ex.rdata);
            end
        end
    endtask

    task automatic test_errors();
        txn_t tbl[8];
        logic ok, e, p; int lat; logic [31:0] r; exp_t ex;
        tbl[0] = '{w: 1'b1, sz: SIZE_WORD, a: 32'h11, st: 4'b1111, wd: 32'h55555555, xe: 1'b1, xr: 32'h0};
        tbl[1] = '{w: 1'b0, sz: SIZE_WORD, a: 32'h10, st: 4'b0000, wd: 32'h0, xe: 1'b0, xr: 32'h1234BEEF};
        tbl[2] = '{w: 1'b1, sz: SIZE_BYTE, a: 32'h10, st: 4'b0010, wd: 32'h77777777, xe: 1'b1, xr: 32'h0};
        tbl[3] = '{w: 1'b1, sz: SIZE_BYTE, a: 32'h12, st: 4'b0000, wd: 32'h66666666, xe: 1'b1, xr: 32'h0};
        tbl[4] = '{w: 1'b0, sz: 2'b11,     a: 32'h10, st: 4'b0000, wd: 32'h0, xe: 1'b1, xr: 32'h0};
        tbl[5] = '{w: 1'b0, sz: SIZE_HALF, a: 32'h13, st: 4'b0000, wd: 32'h0, xe: 1'b1, xr: 32'h0};
        tbl[6] = '{w: 1'b0, sz: SIZE_BYTE, a: 32'h4013, st: 4'b0000, wd: 32'h0, xe: 1'b0, xr: 32'h1234BEEF};
        tbl[7] = '{w: 1'b0, sz: SIZE_WORD, a: 32'h10, st: 4'b0000, wd: 32'h0, xe: 1'b0, xr: 32'h1234BEEF};
        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], ok, lat, r, e, p, ex);
            checks++;
            if (!ok || lat != 2 || e !== ex.err || r !== ex.rdata || !p) begin
                errors++;
                $display("FAIL errors[%0d]: ok=%b lat=%0d err=%b rdata=%h pulse=%b, want ok=1 lat=2 err=%b rdata=%h pulse=1",
                         i, ok, lat, e, r, p, ex.err, ex.rdata);
            end
        end
    endtask

    task automatic test_hold_req();
        int   accepts = 0;
        logic bad_ok = 1'b0, bad_dok = 1'b0, bad_err = 1'b0;
        @(negedge clk);
        req3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (req3 && addr_ok3) accepts++;
            if (addr_ok3 !== ((i % 4) == 0)) bad_ok = 1'b1;
            if (data_ok3 !== ((i % 4) == 3)) bad_dok = 1'b1;
            if (data_ok3 === 1'b1 && err3 !== 1'b0) bad_err = 1'b1;
            @(negedge clk);
        end
        req3 = 1'b0;
        checks++;
        if (accepts != 2) begin
            errors++;
            $display("FAIL hold_accepts: got %0d accepts, want 2", accepts);
        end
        checks++;
        if (bad_ok || bad_dok || bad_err) begin
            errors++;
            $display("FAIL hold_timing: addr_ok_bad=%b data_ok_bad=%b err_bad=%b, want all 0",
                     bad_ok, bad_dok, bad_err);
        end
    endtask

    task automatic test_reset_abort();
        txn_t tbl[2];
        logic ok, e, p, seen; int lat; logic [31:0] r; exp_t ex;
        tbl[0] = '{w: 1'b1, sz: SIZE_WORD, a: 32'h20, st: 4'b1111, wd: 32'h55667788, xe: 1'b0, xr: 32'h0};
        tbl[1] = '{w: 1'b0, sz: SIZE_WORD, a: 32'h20, st: 4'b0000, wd: 32'h0, xe: 1'b0, xr: 32'h55667788};
        for (int i = 0; i < 2; i++) begin
            run_txn(tbl[i], ok, lat, r, e, p, ex);
            checks++;
            if (!ok || lat != 2 || e !== ex.err || r !== ex.rdata || !p) begin
                errors++;
                $display("FAIL abort_setup[%0d]: ok=%b lat=%0d err=%b rdata=%h, want ok=1 lat=2 err=%b rdata=%h",
                         i, ok, lat, e, r, ex.err, ex.rdata);
            end
        end
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = SIZE_WORD; addr = 32'h20; wstrb = 4'b1111; wdata = 32'h11111111;
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (data_ok !== 1'b0) seen = 1'b1;
            rst = 1'b0;
        end
        checks++;
        if (seen || rdata !== 32'h0 || err !== 1'b0 || addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_resp: data_ok_seen=%b rdata=%h err=%b addr_ok=%b, want 0 00000000 0 1",
                     seen, rdata, err, addr_ok);
        end
        run_txn(tbl[1], ok, lat, r, e, p, ex);
        checks++;
        if (!ok || lat != 2 || e !== ex.err || r !== ex.rdata || !p) begin
            errors++;
            $display("FAIL abort_readback: ok=%b lat=%0d err=%b rdata=%h, want ok=1 lat=2 err=%b rdata=%h",
                     ok, lat, e, r, ex.err, ex.rdata);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_partial();
        test_errors();
        test_hold_req();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
